// File: rtl/cache_line_fill.sv
// Miss-refill engine: fetches one 16-word line over a req/ack word port, assembles the
// cache line image (tag | words | valid) and writes it into the cache with a single strobe.
module cache_line_fill #(
    parameter int WORD_SIZE    = 32,
    parameter int INDEX_BITS   = 5,
    parameter int BLOCK_OFFSET = 6,
    parameter int TAG_BITS     = 32 - INDEX_BITS - BLOCK_OFFSET,
    parameter int STATUS_BITS  = 1,
    parameter int LINE_LENGTH  = TAG_BITS + (2**BLOCK_OFFSET)*8 + STATUS_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   miss_valid_i,
    input  logic [31:0]            miss_addr_i,
    output logic                   busy_o,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [WORD_SIZE-1:0]   mem_rdata_i,
    output logic [LINE_LENGTH-1:0] new_cache_line_o,
    output logic                   full_line_wr_o,
    output logic [1:0]             state_o
);

    localparam int CNT_W = BLOCK_OFFSET - 2;
    localparam logic [CNT_W-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        WRITE  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            line_addr_q, line_addr_d;
    logic [LINE_LENGTH-1:0] line_q, line_d;
    logic                   busy_q, busy_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        line_addr_d    = line_addr_q;
        line_d         = line_q;
        mem_req_o      = 1'b0;
        mem_addr_o     = '0;
        full_line_wr_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_valid_i) begin
                    line_addr_d = miss_addr_i;
                    cnt_d       = '0;
                    line_d[LINE_LENGTH-1 -: TAG_BITS] = miss_addr_i[31 -: TAG_BITS];
                    line_d[0]   = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {line_addr_q[31:BLOCK_OFFSET], cnt_q, 2'b00};
                if (mem_ack_i) begin
                    line_d[STATUS_BITS + WORD_SIZE*int'(cnt_q) +: WORD_SIZE] = mem_rdata_i;
                    // The increment from the last word wraps to zero as the fill completes.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) state_d = WRITE;
                end
            end
            WRITE: begin
                full_line_wr_o = 1'b1;
                state_d        = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign busy_o           = busy_q;
    assign new_cache_line_o = line_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: zero-wait and wait-state fills, reset mid-fill,
// held/toggling miss requests, spurious acks and the all-ones address corner.
module tb_cache_line_fill;

    localparam int LL = 534;

    logic          clk;
    logic          rst;
    logic          miss_valid;
    logic [31:0]   miss_addr;
    logic          busy;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [LL-1:0] new_cache_line;
    logic          full_line_wr;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    logic [31:0] last_ea;

    cache_line_fill dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .miss_valid_i     (miss_valid),
        .miss_addr_i      (miss_addr),
        .busy_o           (busy),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata),
        .new_cache_line_o (new_cache_line),
        .full_line_wr_o   (full_line_wr),
        .state_o          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (full_line_wr) wr_pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [LL-1:0] ln, input int k);
        return ln[1 + 32*k +: 32];
    endfunction

    task automatic start_miss(input logic [31:0] addr, input bit hold);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        check("accept_state", state, 2'd1);
        check("accept_busy", busy, 1'b1);
        if (!hold) miss_valid = 1'b0;
    endtask

    // Serves a fill already in progress at addr; gap = idle cycles before each ack.
    task automatic serve(input logic [31:0] addr, input logic [31:0] dbase, input int gap,
                         input bit hold);
        logic [31:0]   ea;
        logic [LL-1:0] ln;
        int            wr0;
        wr0 = wr_pulses;
        for (int k = 0; k < 16; k++) begin
            ea = {addr[31:6], k[3:0], 2'b00};
            for (int w = 0; w < gap; w++) begin
                mem_ack = 1'b0;
                if (hold) miss_addr = 32'h1357_9BDF ^ (k << 8) ^ w;
                check("req_wait", mem_req, 1'b1);
                check("addr_wait", mem_addr, ea);
                tick();
            end
            if (hold) miss_addr = 32'h8000_0000 | (k << 12);
            mem_ack   = 1'b1;
            mem_rdata = dbase + k;
            check("req", mem_req, 1'b1);
            check("addr", mem_addr, ea);
            last_ea = mem_addr;
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("wr_pulse", full_line_wr, 1'b1);
        check("write_state", state, 2'd2);
        check("write_busy", busy, 1'b1);
        check("write_req", mem_req, 1'b0);
        ln = new_cache_line;
        for (int k = 0; k < 16; k++) check("word", word_of(ln, k), dbase + k);
        check("valid", ln[0], 1'b1);
        check("tag", ln[LL-1 -: 21], addr[31:11]);
        tick();
        check("settle_wr", full_line_wr, 1'b0);
        check("settle_state", state, 2'd3);
        check("settle_busy", busy, 1'b1);
        tick();
        check("idle_state", state, 2'd0);
        check("idle_busy", busy, 1'b0);
        check("one_pulse", wr_pulses - wr0, 1);
        check("hold_line", word_of(new_cache_line, 15), dbase + 15);
    endtask

    initial begin
        logic [LL-1:0] ln;
        int            wr0;
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wr", full_line_wr, 1'b0);
        check("rst_state", state, 2'd0);
        check("rst_line", new_cache_line[63:0], 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Zero-wait fill at 0x1A44: addresses 0x1A40..0x1A7C, tag 3.
        start_miss(32'h0000_1A44, 1'b0);
        check("t1_first_addr", mem_addr, 32'h0000_1A40);
        serve(32'h0000_1A44, 32'hA000_0000, 0, 1'b0);
        check("t1_last_addr", last_ea, 32'h0000_1A7C);
        check("t1_tag", new_cache_line[LL-1 -: 21], 21'h000003);

        // Wait states: ack every third cycle.
        start_miss(32'h0001_2380, 1'b0);
        serve(32'h0001_2380, 32'h5500_1000, 2, 1'b0);

        // Reset after word 7 drops the partial line.
        wr0 = wr_pulses;
        start_miss(32'h0000_2000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            mem_ack = 1'b1; mem_rdata = 32'hC0DE_0000 + k;
            tick();
        end
        mem_ack = 1'b0;
        check("pre_rst_addr", mem_addr, 32'h0000_2020);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_state", state, 2'd0);
        ln = new_cache_line;
        check("mid_rst_w0", word_of(ln, 0), 32'h0);
        check("mid_rst_w7", word_of(ln, 7), 32'h0);
        check("mid_rst_tag", ln[LL-1 -: 21], 21'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("no_wr_after_rst", wr_pulses - wr0, 0);
        start_miss(32'h0000_3004, 1'b0);
        check("refetch_word0", mem_addr, 32'h0000_3000);
        serve(32'h0000_3004, 32'h1111_0000, 1, 1'b0);

        // miss_valid held high with a toggling address: first address wins.
        start_miss(32'h4000_0100, 1'b1);
        serve(32'h4000_0100, 32'h7000_0000, 1, 1'b1);
        check("t4_tag", new_cache_line[LL-1 -: 21], 21'h080000);
        miss_addr = 32'h5555_0040;
        tick();
        check("t4_second_state", state, 2'd1);
        check("t4_second_addr", mem_addr, 32'h5555_0040);
        miss_valid = 1'b0;
        serve(32'h5555_0040, 32'h2222_0000, 0, 1'b0);

        // Spurious acks in IDLE change nothing.
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        ln = new_cache_line;
        tick(); tick(); tick();
        check("spur_state", state, 2'd0);
        check("spur_busy", busy, 1'b0);
        check("spur_req", mem_req, 1'b0);
        check("spur_line_lo", new_cache_line[63:0], ln[63:0]);
        check("spur_w15", word_of(new_cache_line, 15), 32'h2222_000F);
        mem_ack = 1'b0; mem_rdata = '0;
        start_miss(32'h0000_1A44, 1'b0);
        serve(32'h0000_1A44, 32'hA000_0000, 0, 1'b0);

        // All-ones address corner.
        start_miss(32'hFFFF_FFC0, 1'b0);
        check("t6_first_addr", mem_addr, 32'hFFFF_FFC0);
        serve(32'hFFFF_FFC0, 32'h0F0F_0000, 0, 1'b0);
        check("t6_last_addr", last_ea, 32'hFFFF_FFFC);
        check("t6_tag", new_cache_line[LL-1 -: 21], 21'h1FFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
